spi_rom_stream_reader: RTL
==========================

// Module: spi_rom_stream_reader
// PURPOSE
//   Upstream fetch stage for the VGA SPI-ROM design. Issues a SPI READ (0x03) to an external
//   ROM with a 24-bit address, then streams LEN bytes back as a byte/strobe stream. The stream
//   feeds the pixel line buffer ahead of the VGA output logic. SPI mode 0, SCLK = clk/2, no backpressure.
// PARAMETERS
//   LEN_W   10  width of byte-count input; max transfer 2**LEN_W-1 bytes
//   CS_GAP  2   clk cycles spi_cs_n held high after a transfer before busy drops (>=1)
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   rst         in   1      asynchronous, active-high reset
//   start       in   1      1-cycle request; sampled only in IDLE
//   addr        in   24     ROM byte address, captured on accepted start
//   len         in   LEN_W  byte count, captured on accepted start; 0 = request ignored
//   abort       in   1      synchronous cancel of an in-flight transfer
//   busy        out  1      high from cycle after accepted start until back in IDLE
//   done        out  1      1-cycle pulse on completion (not on abort)
//   byte_out    out  8      received byte, MSB first on wire; held until next byte_valid
//   byte_valid  out  1      1-cycle strobe, byte_out valid this cycle
//   spi_cs_n    out  1      ROM chip select, active low
//   spi_sclk    out  1      SPI clock, idle low
//   spi_mosi    out  1      command/address data
//   spi_miso    in   1      ROM data (synchronous to clk by board timing)
// BEHAVIOUR
//   Reset (async, any state): IDLE; busy=0 done=0 byte_valid=0 byte_out=0 spi_cs_n=1 spi_sclk=0 spi_mosi=0.
//   All outputs registered. States: IDLE -> CMD_ADDR -> DATA -> GAP -> IDLE.
//   IDLE: start=1 && len!=0 at edge T: latch {8'h03,addr} into 32-bit shift reg, len into counter.
//     start with len==0, or start while busy: ignored, no outputs change.
//   Bit timing: each SPI bit = 2 clk: low phase (sclk=0, mosi updated) then high phase (sclk=1).
//   CMD_ADDR: cycles T+1..T+64, cs_n=0; 32 bits MSB first (0x03 then addr[23:0]).
//   DATA: bit j of byte k: low phase at T+65+16k+2j, high phase at T+66+16k+2j.
//     spi_miso sampled at clk edge ending each high phase; shift in MSB first.
//     byte_valid=1 in cycle T+81+16k (overlaps next bit's low phase); SCLK never stalls.
//     spi_mosi=0 throughout DATA.
//   After last byte's 8th high phase: GAP, cs_n=1, sclk=0 for CS_GAP cycles.
//     The final byte_valid coincides with the first GAP cycle.
//     done=1 in last GAP cycle; busy=0 from next cycle. One-byte total: done at T+80+CS_GAP.
//   abort=1 in any non-IDLE state: next cycle cs_n=1, sclk=0, busy=0, IDLE.
//     No done; partial byte discarded; no byte_valid. abort in IDLE: no effect.
//   abort and byte_valid-producing edge together: abort wins, byte_valid suppressed.
//   Address not incremented/wrapped here; ROM handles auto-increment past 0xFFFFFF.
//   Counter: len counts down per byte; len=2**LEN_W-1 legal.
// TESTING
//   start, addr=24'h012345, len=1 -> MOSI bits = 0x03012345, 64 clk with cs_n=0; model returns 0xA5 -> byte_valid @T+81 with byte_out=8'hA5, done @T+80+CS_GAP.
//   len=4, ROM model bytes 11,22,33,44 -> 4 strobes spaced 16 clk, correct order, exactly one done, cs_n never glitches high mid-transfer.
//   start with len=0, and second start while busy -> no cs_n activity, busy/transfer unaffected.
//   abort during CMD_ADDR bit 10, and during DATA byte 2 bit 3 -> cs_n=1 next cycle, no done, no further byte_valid; a new start works normally.
//   rst asserted mid-DATA (async, between clk edges) -> all outputs at reset values immediately; clean transfer afterwards.
//   Back-to-back: start on first IDLE cycle after done -> cs_n high gap >= CS_GAP+1 cycles between transfers.

Source files
------------

// File: rtl/spi_rom_stream_reader.sv
// SPI-ROM READ (0x03) fetch engine: shifts out command plus 24-bit address in mode 0
// at clk/2, then streams LEN received bytes as a byte/strobe pair with no backpressure.
module spi_rom_stream_reader #(
    parameter int LEN_W  = 10,
    parameter int CS_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD_ADDR = 2'd1,
        DATA     = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t             state_r;
    // Bits 30..0 of {8'h03, addr}; bit 31 is a constant zero driven at accept time.
    logic [30:0]        shift_r;
    logic [4:0]         bit_cnt_r;
    logic [7:0]         rx_r;
    logic [LEN_W-1:0]   len_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [7:0]         rx_next_s;

    // Byte assembled including the bit sampled at the edge ending the current high phase.
    always_comb begin
        rx_next_s = {rx_r[6:0], spi_miso};
    end

    // Transfer FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= 31'd0;
            bit_cnt_r  <= 5'd0;
            rx_r       <= 8'h00;
            len_cnt_r  <= {LEN_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            done       <= 1'b0;
            byte_valid <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                // Cancel wins over everything, including a byte completing this edge.
                state_r   <= IDLE;
                busy      <= 1'b0;
                spi_cs_n  <= 1'b1;
                spi_sclk  <= 1'b0;
                spi_mosi  <= 1'b0;
                bit_cnt_r <= 5'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && (len != {LEN_W{1'b0}})) begin
                            state_r   <= CMD_ADDR;
                            shift_r   <= {7'h03, addr};
                            len_cnt_r <= len;
                            bit_cnt_r <= 5'd0;
                            busy      <= 1'b1;
                            spi_cs_n  <= 1'b0;
                            spi_sclk  <= 1'b0;
                            spi_mosi  <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    CMD_ADDR: begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt_r == 5'd31) begin
                                state_r   <= DATA;
                                spi_mosi  <= 1'b0;
                                bit_cnt_r <= 5'd0;
                            end else begin
                                spi_mosi  <= shift_r[30];
                                shift_r   <= {shift_r[29:0], 1'b0};
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            rx_r     <= rx_next_s;
                            if (bit_cnt_r[2:0] == 3'd7) begin
                                byte_out   <= rx_next_s;
                                byte_valid <= 1'b1;
                                bit_cnt_r  <= 5'd0;
                                len_cnt_r  <= len_cnt_r - LEN_W'(1);
                                if (len_cnt_r == LEN_W'(1)) begin
                                    state_r   <= GAP;
                                    spi_cs_n  <= 1'b1;
                                    gap_cnt_r <= GAP_W'(CS_GAP - 1);
                                    done      <= (CS_GAP == 1);
                                end else begin
                                    state_r <= DATA;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt_r == {GAP_W{1'b0}}) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                            done      <= (gap_cnt_r == GAP_W'(1));
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        busy     <= 1'b0;
                        spi_cs_n <= 1'b1;
                        spi_sclk <= 1'b0;
                        spi_mosi <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
